// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader for the instruction memory. Receives a byte
//   stream made of a 16-bit big-endian word count N followed by N big-endian
//   32-bit instruction words, writes them to instruction memory starting at
//   word address 0, and keeps the CPU in reset until the load is finished.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   start     in   one-cycle pulse, begins a load (only in IDLE or DONE)
//   in_valid  in   byte stream valid
//   in_data   in   byte stream data
//   in_ready  out  byte accepted when in_valid && in_ready
//   im_we     out  instruction-memory write strobe, one cycle per word
//   im_addr   out  word address for im_wdata
//   im_wdata  out  assembled instruction word
//   cpu_hold  out  1 = CPU must be held in reset
//   done      out  1 = load complete, CPU released
//   err       out  sticky: header word count exceeded memory depth
//   word_cnt  out  words accepted so far in the current load
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           word_cnt
);

    // Memory depth held in 17 bits so that a depth of 2**16 still compares
    // correctly against 16-bit counts.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] n_reg, n_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [15:0] word_cnt_reg, word_cnt_next;
    logic        err_reg, err_next;

    logic        accept;
    logic [15:0] len_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            byte_idx_reg <= '0;
            wdata_reg    <= '0;
            word_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            byte_idx_reg <= byte_idx_next;
            wdata_reg    <= wdata_next;
            word_cnt_reg <= word_cnt_next;
            err_reg      <= err_next;
        end
    end

    assign in_ready = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                      (state_reg == S_DATA);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        byte_idx_next = byte_idx_reg;
        wdata_next    = wdata_reg;
        word_cnt_next = word_cnt_reg;
        err_next      = err_reg;
        len_full      = {n_reg[15:8], in_data};

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next    = S_LEN_HI;
                    n_next        = '0;
                    byte_idx_next = '0;
                    word_cnt_next = '0;
                    err_next      = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    n_next[15:8] = in_data;
                    state_next   = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    n_next[7:0] = in_data;
                    if ({1'b0, len_full} > DEPTH) begin
                        err_next = 1'b1;
                    end
                    state_next = (len_full == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                // Shift in MSB first: after four bytes, byte 0 sits in [31:24].
                if (accept) begin
                    wdata_next    = {wdata_reg[23:0], in_data};
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_next = word_cnt_reg + 16'd1;
                if (({1'b0, word_cnt_reg} + 17'd1) < {1'b0, n_reg}) begin
                    state_next = S_DATA;
                end else begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Words beyond the memory depth are consumed but never written, so the
    // truncated address can never alias onto already-loaded words.
    assign im_we    = (state_reg == S_WRITE) && ({1'b0, word_cnt_reg} < DEPTH);
    assign im_addr  = word_cnt_reg[ADDR_WIDTH-1:0];
    assign im_wdata = wdata_reg;
    assign cpu_hold = (state_reg != S_DONE);
    assign done     = (state_reg == S_DONE);
    assign err      = err_reg;
    assign word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [15:0]   word_cnt;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] vec [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (im_addr !== e.addr || im_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write: addr=%0d data=0x%08h, expected addr=%0d data=0x%08h",
                             im_addr, im_wdata, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=0x%08h ok", im_addr, im_wdata);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full load of vec[0..n-1]; start is pulsed before data byte inject_at (-1 = never).
    task automatic run_load(input int n, input int gap, input int inject_at);
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(n);
        pulse_start();
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("done_after_start", {31'd0, done}, 32'd0);
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        for (int i = 0; i < n; i++) begin
            if (i < DEPTH) begin
                wr_t e;
                e.addr = AW'(i);
                e.data = vec[i];
                sb.push_back(e);
            end
            w = vec[i];
            for (int j = 0; j < 4; j++) begin
                if (inject_at == i * 4 + j) pulse_start();
                send_byte(w[31 - 8*j -: 8], gap);
            end
            @(negedge clk);
            check("we_latency", {31'd0, im_we}, (i < DEPTH) ? 32'd1 : 32'd0);
            check("ready_in_write", {31'd0, in_ready}, 32'd0);
            check("hold_in_write", {31'd0, cpu_hold}, 32'd1);
        end
        @(negedge clk);
        check("done", {31'd0, done}, 32'd1);
        check("cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
        check("word_cnt", {16'd0, word_cnt}, 32'(n));
        check("err", {31'd0, err}, (n > DEPTH) ? 32'd1 : 32'd0);
        check("ready_in_done", {31'd0, in_ready}, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("load n=%0d gap=%0d done=%0d err=%0d word_cnt=%0d", n, gap, done, err, word_cnt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_im_we"},    {31'd0, im_we},    32'd0);
        check({tag, "_im_addr"},  {30'd0, im_addr},  32'd0);
        check({tag, "_im_wdata"}, im_wdata,          32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_err"},      {31'd0, err},      32'd0);
        check({tag, "_word_cnt"}, {16'd0, word_cnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        $display("reset values checked");
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", {31'd0, cpu_hold}, 32'd1);
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // Basic two-word load.
        vec[0] = 32'h2008000A;
        vec[1] = 32'h00000000;
        run_load(2, 0, -1);

        // Empty program: header 00 00 goes straight to DONE, no write.
        run_load(0, 0, -1);

        // Same load with 3 idle cycles between every byte.
        run_load(2, 3, -1);

        // Overflow: 5 words into a 4-word memory.
        vec[0] = 32'h01020304;
        vec[1] = 32'h05060708;
        vec[2] = 32'h090A0B0C;
        vec[3] = 32'h0D0E0F10;
        vec[4] = 32'h11121314;
        run_load(5, 0, -1);

        // Restart from DONE must clear err/done/word_cnt.
        pulse_start();
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_err", {31'd0, err}, 32'd0);
        check("restart_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("restart_ready", {31'd0, in_ready}, 32'd1);
        // Finish this load: exactly memory depth (no err), start pulsed mid-data.
        vec[0] = 32'hDEADBEEF;
        vec[1] = 32'hCAFEF00D;
        vec[2] = 32'h12345678;
        vec[3] = 32'h9ABCDEF0;
        begin
            send_byte(8'h00, 0);
            send_byte(8'h04, 0);
            for (int i = 0; i < 4; i++) begin
                wr_t e;
                logic [31:0] w;
                e.addr = AW'(i);
                e.data = vec[i];
                sb.push_back(e);
                w = vec[i];
                for (int j = 0; j < 4; j++) begin
                    if (i == 1 && j == 2) pulse_start();
                    send_byte(w[31 - 8*j -: 8], 0);
                end
                @(negedge clk);
                check("we_latency_full", {31'd0, im_we}, 32'd1);
            end
            @(negedge clk);
            check("full_done", {31'd0, done}, 32'd1);
            check("full_err", {31'd0, err}, 32'd0);
            check("full_word_cnt", {16'd0, word_cnt}, 32'd4);
            check("full_sb_drained", 32'(sb.size()), 32'd0);
            $display("load n=4 with mid-data start done=%0d err=%0d", done, err);
        end

        // Second load overwrites from address 0; start pulse mid-data ignored.
        vec[0] = 32'hA5A55A5A;
        vec[1] = 32'h0F0F0F0F;
        run_load(2, 1, 5);

        // Reset in the middle of word 1.
        vec[0] = 32'h11223344;
        vec[1] = 32'h55667788;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        begin
            wr_t e;
            e.addr = '0;
            e.data = vec[0];
            sb.push_back(e);
        end
        for (int j = 0; j < 4; j++) send_byte(vec[0][31 - 8*j -: 8], 0);
        @(negedge clk);
        check("rst_case_we", {31'd0, im_we}, 32'd1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        $display("mid-load reset values checked");
        @(negedge clk);
        rst = 1'b0;
        vec[0] = 32'h2008000A;
        vec[1] = 32'h00000000;
        run_load(2, 0, -1);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
